// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared state encoding, limits and vote helper for the UART receiver
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam int MIN_DATA_W = 5;
  localparam int MIN_PRESC  = 4;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// rtl/uart_rx_sampler.sv - per-bit edge counter with 3-sample majority vote around mid-bit
module uart_rx_sampler
  import uart_rx_pkg::*;
#(
  parameter int PRESC_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic [PRESC_W-1:0] p,
  input  logic               rx_in,
  output logic               bit_done,
  output logic               bit_val
);

  logic [PRESC_W-1:0] cnt;
  logic [PRESC_W:0]   mid, last;
  logic [1:0]         smp;
  logic               vote;
  logic               at_lo, at_mid, at_hi;

  assign mid    = {1'b0, p} >> 1;
  assign last   = {1'b0, p} - 1'b1;
  assign at_lo  = ({1'b0, cnt} == mid - 1'b1);
  assign at_mid = ({1'b0, cnt} == mid);
  assign at_hi  = ({1'b0, cnt} == mid + 1'b1);

  assign bit_done = run && ({1'b0, cnt} == last);
  // At the minimum prescale the third sample lands on the decision edge, so bypass the register.
  assign bit_val  = at_hi ? maj3(smp[0], smp[1], rx_in) : vote;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      smp  <= '0;
      vote <= 1'b0;
    end else if (!run) begin
      cnt <= '0;
    end else begin
      cnt <= bit_done ? '0 : cnt + 1'b1;
      if (at_lo)  smp[0] <= rx_in;
      if (at_mid) smp[1] <= rx_in;
      if (at_hi)  vote   <= maj3(smp[0], smp[1], rx_in);
    end
  end

endmodule

// File: rtl/uart_rx_ctrl_gen2.sv
// rtl/uart_rx_ctrl_gen2.sv - UART RX framing FSM, deserialiser, parity/stop checks (optional BREAK_DETECT_EN)
module uart_rx_ctrl_gen2
  import uart_rx_pkg::*;
#(
  parameter int MAX_DATA_W = 9,
  parameter int PRESC_W    = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic [PRESC_W-1:0]    prescale,
  input  logic [3:0]            data_len,
  input  logic                  par_en,
  input  logic                  par_odd,
  input  logic                  stop2,
  output logic [MAX_DATA_W-1:0] rx_data,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  busy
`ifdef BREAK_DETECT_EN
  ,
  output logic                  brk_det
`endif
);

  state_t                state;
  logic [PRESC_W-1:0]    p_eff, p_lat, p_cur;
  logic [3:0]            len_eff, len_lat, bit_cnt;
  logic                  par_en_l, par_odd_l, stop2_l, stop_idx;
  logic [MAX_DATA_W-1:0] shreg;
  logic                  par_acc, par_bad, stp_bad;
  logic                  start, run, bit_done, bit_val, last_stop, stp_fin;
`ifdef BREAK_DETECT_EN
  logic                  all_zero, brk_cand, brk_hold, brk_fin;
  logic [PRESC_W-1:0]    hi_cnt;
`endif

  assign p_eff   = (prescale < PRESC_W'(MIN_PRESC)) ? PRESC_W'(MIN_PRESC) : prescale;
  assign len_eff = (data_len < 4'(MIN_DATA_W)) ? 4'(MIN_DATA_W) :
                   (data_len > 4'(MAX_DATA_W)) ? 4'(MAX_DATA_W) : data_len;
  assign p_cur   = (state == IDLE) ? p_eff : p_lat;

`ifdef BREAK_DETECT_EN
  assign start   = (state == IDLE) && !rx_in && !brk_hold;
  assign brk_fin = stop_idx ? brk_cand : (all_zero && !bit_val);
`else
  assign start   = (state == IDLE) && !rx_in;
`endif
  assign run       = start || (state != IDLE);
  assign last_stop = !stop2_l || stop_idx;
  assign stp_fin   = stp_bad || !bit_val;

  uart_rx_sampler #(.PRESC_W(PRESC_W)) u_sampler (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .p        (p_cur),
    .rx_in    (rx_in),
    .bit_done (bit_done),
    .bit_val  (bit_val)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      p_lat      <= PRESC_W'(MIN_PRESC);
      len_lat    <= 4'(MIN_DATA_W);
      par_en_l   <= 1'b0;
      par_odd_l  <= 1'b0;
      stop2_l    <= 1'b0;
      bit_cnt    <= '0;
      stop_idx   <= 1'b0;
      shreg      <= '0;
      par_acc    <= 1'b0;
      par_bad    <= 1'b0;
      stp_bad    <= 1'b0;
      rx_data    <= '0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
      busy       <= 1'b0;
`ifdef BREAK_DETECT_EN
      all_zero   <= 1'b0;
      brk_cand   <= 1'b0;
      brk_hold   <= 1'b0;
      hi_cnt     <= '0;
      brk_det    <= 1'b0;
`endif
    end else begin
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
`ifdef BREAK_DETECT_EN
      brk_det    <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (start) begin
            p_lat     <= p_eff;
            len_lat   <= len_eff;
            par_en_l  <= par_en;
            par_odd_l <= par_odd;
            stop2_l   <= stop2;
            bit_cnt   <= '0;
            stop_idx  <= 1'b0;
            shreg     <= '0;
            par_acc   <= 1'b0;
            par_bad   <= 1'b0;
            stp_bad   <= 1'b0;
`ifdef BREAK_DETECT_EN
            all_zero  <= 1'b1;
`endif
            state     <= START;
            busy      <= 1'b1;
          end
`ifdef BREAK_DETECT_EN
          // After a break the line must idle high for a full bit time before a new start counts.
          else if (brk_hold) begin
            if (!rx_in) begin
              hi_cnt <= '0;
            end else if (hi_cnt == p_lat - 1'b1) begin
              brk_hold <= 1'b0;
              hi_cnt   <= '0;
            end else begin
              hi_cnt <= hi_cnt + 1'b1;
            end
          end
`endif
        end
        START: if (bit_done) begin
          if (bit_val) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state <= DATA;
          end
        end
        DATA: if (bit_done) begin
          shreg[bit_cnt] <= bit_val;
          par_acc        <= par_acc ^ bit_val;
`ifdef BREAK_DETECT_EN
          if (bit_val) all_zero <= 1'b0;
`endif
          if (bit_cnt == len_lat - 4'd1) state <= par_en_l ? PARITY : STOP;
          else                          bit_cnt <= bit_cnt + 4'd1;
        end
        PARITY: if (bit_done) begin
          if (bit_val != (par_acc ^ par_odd_l)) par_bad <= 1'b1;
`ifdef BREAK_DETECT_EN
          if (bit_val) all_zero <= 1'b0;
`endif
          state <= STOP;
        end
        STOP: if (bit_done) begin
          if (!last_stop) begin
            stop_idx <= 1'b1;
            stp_bad  <= stp_fin;
`ifdef BREAK_DETECT_EN
            brk_cand <= brk_fin;
`endif
          end else begin
            state      <= IDLE;
            busy       <= 1'b0;
            par_err    <= par_bad;
            data_valid <= !par_bad && !stp_fin;
            if (!par_bad && !stp_fin) rx_data <= shreg;
`ifdef BREAK_DETECT_EN
            stp_err <= stp_fin && !brk_fin;
            brk_det <= brk_fin;
            if (brk_fin) begin
              brk_hold <= 1'b1;
              hi_cnt   <= '0;
            end
`else
            stp_err <= stp_fin;
`endif
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl_gen2.sv
// tb/tb_uart_rx_ctrl_gen2.sv - randomized self-checking bench for uart_rx_ctrl_gen2
module tb_uart_rx_ctrl_gen2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_in = 1'b1;
  logic [5:0] prescale = 6'd8;
  logic [3:0] data_len = 4'd8;
  logic       par_en = 1'b0, par_odd = 1'b0, stop2 = 1'b0;
  logic [8:0] rx_data;
  logic       data_valid, par_err, stp_err, busy;
  logic       brk;
`ifdef BREAK_DETECT_EN
  logic       brk_det;
  assign brk = brk_det;
`else
  assign brk = 1'b0;
`endif

  uart_rx_ctrl_gen2 dut (
    .clk        (clk),
    .rst        (rst),
    .rx_in      (rx_in),
    .prescale   (prescale),
    .data_len   (data_len),
    .par_en     (par_en),
    .par_odd    (par_odd),
    .stop2      (stop2),
    .rx_data    (rx_data),
    .data_valid (data_valid),
    .par_err    (par_err),
    .stp_err    (stp_err),
    .busy       (busy)
`ifdef BREAK_DETECT_EN
    ,
    .brk_det    (brk_det)
`endif
  );

  always #5 clk = ~clk;

  int         n_vec = 0;
  int         n_err = 0;
  int         cyc = 0;
  logic [8:0] last_good = '0;

  typedef struct {
    int         cyc;
    logic [3:0] f;
    logic [8:0] d;
  } ev_t;
  ev_t evq[$];

  // Every output pulse is logged with the clock it appeared on.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (data_valid || par_err || stp_err || brk)
      evq.push_back('{cyc: cyc, f: {data_valid, par_err, stp_err, brk}, d: rx_data});
  end

  task automatic send_frame(input int presc, input int dlen, input bit pe, input bit po,
                            input bit s2, input logic [8:0] data, input bit bad_par,
                            input bit [1:0] bad_stop, input string name);
    int         p, l, ones;
    bit         bits[$];
    bit         parbit, stop_bad, exp_dv, exp_pe, exp_se, exp_bd;
    logic [8:0] d;
    logic [3:0] exp_f;
    p = (presc < 4) ? 4 : presc;
    l = (dlen < 5) ? 5 : (dlen > 9) ? 9 : dlen;
    d = '0;
    ones = 0;
    bits.push_back(1'b0);
    for (int i = 0; i < l; i++) begin
      d[i] = data[i];
      ones += int'(data[i]);
      bits.push_back(data[i]);
    end
    parbit = bit'(ones % 2) ^ po ^ bad_par;
    if (pe) bits.push_back(parbit);
    bits.push_back(!bad_stop[0]);
    if (s2) bits.push_back(!bad_stop[1]);

    exp_pe   = pe && (((ones + int'(parbit)) % 2) != int'(po));
    stop_bad = bad_stop[0] || (s2 && bad_stop[1]);
    exp_se   = stop_bad;
    exp_bd   = 1'b0;
`ifdef BREAK_DETECT_EN
    if (ones == 0 && !(pe && parbit) && bad_stop[0]) begin
      exp_bd = 1'b1;
      exp_se = 1'b0;
    end
`endif
    exp_dv = !exp_pe && !stop_bad;
    if (exp_dv) last_good = d;
    exp_f = {exp_dv, exp_pe, exp_se, exp_bd};

    prescale = 6'(presc);
    data_len = 4'(dlen);
    par_en   = pe;
    par_odd  = po;
    stop2    = s2;
    foreach (bits[i]) begin
      rx_in = bits[i];
      if (i == 1) begin
        n_vec++;
        if (busy !== 1'b1) begin
          n_err++;
          $display("FAIL %s busy_in_frame: got %b exp 1", name, busy);
        end
        prescale = 6'($urandom_range(0, 63));
        data_len = 4'($urandom);
        par_en   = 1'($urandom);
        par_odd  = 1'($urandom);
        stop2    = 1'($urandom);
      end
      repeat (p) @(negedge clk);
    end

    n_vec++;
    if (evq.size() != 1) begin
      n_err++;
      $display("FAIL %s event_count: got %0d exp 1", name, evq.size());
    end else begin
      n_vec++;
      if (evq[0].cyc !== cyc) begin
        n_err++;
        $display("FAIL %s event_cycle: got %0d exp %0d", name, evq[0].cyc, cyc);
      end
      n_vec++;
      if (evq[0].f !== exp_f) begin
        n_err++;
        $display("FAIL %s flags{dv,pe,se,bd}: got %b exp %b", name, evq[0].f, exp_f);
      end
      n_vec++;
      if (evq[0].d !== last_good) begin
        n_err++;
        $display("FAIL %s rx_data: got %h exp %h", name, evq[0].d, last_good);
      end
    end
    evq.delete();
  endtask

  task automatic idle(input int n);
    rx_in = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_vec++;
    if ({busy, data_valid, par_err, stp_err, brk, rx_data} !== 14'h0) begin
      n_err++;
      $display("FAIL reset_state: got %h exp 0", {busy, data_valid, par_err, stp_err, brk, rx_data});
    end
    rst = 1'b0;
    idle(4);
  endtask

  task automatic test_frames();
    send_frame(8, 8, 0, 0, 0, 9'h0A5, 0, 2'b00, "8n1_a5");
    idle(5);
    send_frame(16, 8, 1, 0, 0, 9'h03C, 1, 2'b00, "8e1_bad_parity");
    idle(3);
    send_frame(8, 7, 1, 1, 1, 9'h055, 0, 2'b10, "7o2_bad_stop2");
    send_frame(8, 7, 1, 1, 1, 9'h02A, 0, 2'b00, "7o2_back_to_back");
    idle(2);
    send_frame(63, 9, 1, 1, 1, 9'h1B3, 0, 2'b00, "max_prescale_9o2");
    send_frame(2, 3, 1, 0, 0, 9'h1F6, 0, 2'b00, "clamped_p4_len5");
    idle(2);
  endtask

  task automatic test_glitch();
    prescale = 6'd8;
    data_len = 4'd8;
    par_en   = 1'b0;
    stop2    = 1'b0;
    rx_in = 1'b0;
    repeat (3) @(negedge clk);
    rx_in = 1'b1;
    repeat (4) @(negedge clk);
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL glitch_busy_hold: got %b exp 1", busy);
    end
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL glitch_busy_drop: got %b exp 0", busy);
    end
    repeat (8) @(negedge clk);
    n_vec++;
    if (evq.size() != 0) begin
      n_err++;
      $display("FAIL glitch_no_flags: got %0d events exp 0", evq.size());
    end
    evq.delete();
  endtask

  task automatic test_reset_mid_frame();
    logic [8:0] v;
    v = 9'h0FF;
    prescale = 6'd8;
    data_len = 4'd8;
    par_en   = 1'b0;
    stop2    = 1'b0;
    rx_in = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx_in = v[i];
      repeat (8) @(negedge clk);
    end
    rx_in = v[3];
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    n_vec++;
    if ({busy, data_valid, par_err, stp_err, brk, rx_data} !== 14'h0) begin
      n_err++;
      $display("FAIL reset_mid_frame: got %h exp 0", {busy, data_valid, par_err, stp_err, brk, rx_data});
    end
    last_good = '0;
    @(negedge clk);
    rst = 1'b0;
    idle(10);
    n_vec++;
    if (evq.size() != 0) begin
      n_err++;
      $display("FAIL reset_abort_silent: got %0d events exp 0", evq.size());
    end
    evq.delete();
    send_frame(8, 8, 0, 0, 0, 9'h081, 0, 2'b00, "after_reset_81");
    idle(3);
  endtask

  task automatic test_break();
    send_frame(8, 8, 0, 0, 0, 9'h000, 0, 2'b01, "break_frame");
`ifdef BREAK_DETECT_EN
    rx_in = 1'b0;
    repeat (16) @(negedge clk);
    rx_in = 1'b1;
    repeat (7) @(negedge clk);
    rx_in = 1'b0;
    @(negedge clk);
    rx_in = 1'b1;
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL break_holdoff: got busy %b exp 0", busy);
    end
    repeat (8) @(negedge clk);
`else
    idle(8);
`endif
    send_frame(8, 8, 0, 0, 0, 9'h05A, 0, 2'b00, "after_break");
    idle(2);
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      int         presc, dlen;
      bit         pe, po, s2, bp;
      bit [1:0]   bs;
      logic [8:0] data;
      presc = $urandom_range(0, 12);
      dlen  = $urandom_range(0, 15);
      pe    = 1'($urandom);
      po    = 1'($urandom);
      s2    = 1'($urandom);
      data  = 9'($urandom);
      bp    = pe && ($urandom_range(0, 3) == 0);
      bs    = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      if (bs[0]) data[0] = 1'b1;
      send_frame(presc, dlen, pe, po, s2, data, bp, bs, $sformatf("random_%0d", n));
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 20));
    end
  endtask

  task automatic test_quiet_end();
    idle(30);
    n_vec++;
    if (evq.size() != 0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL quiet_end: got %0d events busy %b exp 0 events busy 0", evq.size(), busy);
    end
  endtask

  initial begin
    test_reset();
    test_frames();
    test_glitch();
    test_reset_mid_frame();
    test_break();
    test_random();
    test_quiet_end();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
